// File: rtl/gate_window_pkg.sv
// ============================================================================
// Module      : gate_window_pkg
// Description : Shared types and default widths for the gate window sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gate_window_pkg;

    localparam int unsigned c_COUNTER_WIDTH = 32;
    localparam int unsigned c_REPEAT_WIDTH  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_HIGH  = 2'd2,
        ST_GAP   = 2'd3
    } gw_state_t;

endpackage : gate_window_pkg

`default_nettype wire

// File: rtl/gate_window_sequencer_counter.sv
// ============================================================================
// Module      : window_down_counter
// Description : Loadable down counter with a registered zero flag; saturates
//               at zero instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module window_down_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] value,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;
    logic             r_zero;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_count <= '0;
            r_zero  <= 1'b1;
        end else if (load) begin
            r_count <= value;
            r_zero  <= (value == '0);
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
            r_zero  <= (r_count == WIDTH'(1));
        end
    end

    assign zero = r_zero;

endmodule : window_down_counter

`default_nettype wire

// File: rtl/gate_window_sequencer.sv
// ============================================================================
// Module      : gate_window_sequencer
// Description : Emits set/reset strobes that open and close a gate window
//               after a programmable delay, with programmable width.
//               Optional macro GATE_WINDOW_REPEAT_EN adds gap/repeat support.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_window_sequencer
    import gate_window_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH = c_COUNTER_WIDTH
`ifdef GATE_WINDOW_REPEAT_EN
    ,
    parameter int unsigned REPEAT_WIDTH  = c_REPEAT_WIDTH
`endif
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [COUNTER_WIDTH-1:0] delay,
    input  logic [COUNTER_WIDTH-1:0] width,
`ifdef GATE_WINDOW_REPEAT_EN
    input  logic [COUNTER_WIDTH-1:0] gap,
    input  logic [REPEAT_WIDTH-1:0]  repeats,
`endif
    output logic                     set_strobe,
    output logic                     reset_strobe,
    output logic                     busy,
    output logic                     done
);

    gw_state_t                r_state;
    gw_state_t                w_state_nxt;
    logic [COUNTER_WIDTH-1:0] r_width;
    logic [COUNTER_WIDTH-1:0] w_width_m1;
    logic                     w_launch;
    logic                     w_zero;
    logic                     w_load;
    logic                     w_dec;
    logic [COUNTER_WIDTH-1:0] w_load_val;
    logic                     w_set_nxt;
    logic                     w_rst_nxt;
    logic                     w_done_nxt;
    logic                     w_more;
    logic                     r_abort_pend;
    logic                     r_set;
    logic                     r_rst;
    logic                     r_busy;
    logic                     r_done;

    assign w_launch = (r_state == ST_IDLE) && start && !abort;

    // Phases load length-1 so the terminal count is always the zero flag.
    assign w_width_m1 = (r_width == '0) ? '0 : r_width - COUNTER_WIDTH'(1);

`ifdef GATE_WINDOW_REPEAT_EN
    logic [COUNTER_WIDTH-1:0] r_gap;
    logic [COUNTER_WIDTH-1:0] w_gap_m1;
    logic [REPEAT_WIDTH-1:0]  r_win_left;

    assign w_gap_m1 = (r_gap == '0) ? '0 : r_gap - COUNTER_WIDTH'(1);
    assign w_more   = (r_win_left > REPEAT_WIDTH'(1));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_gap      <= '0;
            r_win_left <= '0;
        end else if (w_launch) begin
            r_gap      <= gap;
            r_win_left <= (repeats == '0) ? REPEAT_WIDTH'(1) : repeats;
        end else if (w_rst_nxt && !r_abort_pend && (r_win_left != '0)) begin
            r_win_left <= r_win_left - REPEAT_WIDTH'(1);
        end
    end
`else
    assign w_more = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_width <= '0;
        end else if (w_launch) begin
            r_width <= width;
        end
    end

    window_down_counter #(
        .WIDTH (COUNTER_WIDTH)
    ) u_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (w_load),
        .dec     (w_dec),
        .value   (w_load_val),
        .zero    (w_zero)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_launch) w_state_nxt = ST_DELAY;
            ST_DELAY: begin
                if (abort)       w_state_nxt = ST_IDLE;
                else if (w_zero) w_state_nxt = ST_HIGH;
            end
            ST_HIGH: begin
                if (abort)       w_state_nxt = ST_IDLE;
                else if (w_zero) w_state_nxt = w_more ? ST_GAP : ST_IDLE;
            end
`ifdef GATE_WINDOW_REPEAT_EN
            ST_GAP: begin
                if (abort)       w_state_nxt = ST_IDLE;
                else if (w_zero) w_state_nxt = ST_HIGH;
            end
`endif
            default:             w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_load     = 1'b0;
        w_dec      = 1'b0;
        w_load_val = '0;
        w_set_nxt  = 1'b0;
        w_rst_nxt  = r_abort_pend;
        w_done_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_load     = w_launch;
                w_load_val = delay;
            end
            ST_DELAY, ST_GAP: begin
                if (!abort) begin
                    if (w_zero) begin
                        w_set_nxt  = 1'b1;
                        w_load     = 1'b1;
                        w_load_val = w_width_m1;
                    end else begin
                        w_dec = 1'b1;
                    end
                end
            end
            ST_HIGH: begin
                if (!abort) begin
                    if (w_zero) begin
                        w_rst_nxt = 1'b1;
`ifdef GATE_WINDOW_REPEAT_EN
                        w_load     = w_more;
                        w_load_val = w_gap_m1;
`endif
                        w_done_nxt = !w_more;
                    end else begin
                        w_dec = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // An abort out of HIGH closes the window one cycle later.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_abort_pend <= 1'b0;
            r_set        <= 1'b0;
            r_rst        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_abort_pend <= abort && (r_state == ST_HIGH);
            r_set        <= w_set_nxt;
            r_rst        <= w_rst_nxt;
            r_busy       <= (r_state != ST_IDLE);
            r_done       <= w_done_nxt;
        end
    end

    assign set_strobe   = r_set;
    assign reset_strobe = r_rst;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule : gate_window_sequencer

`default_nettype wire

// File: tb/tb_gate_window_sequencer.sv
// ============================================================================
// Module      : tb_gate_window_sequencer
// Description : Directed self-checking bench; per-run strobe histories are
//               compared against hand-computed cycle masks (bit k = cycle S+k).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gate_window_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [31:0] delay;
    logic [31:0] width;
`ifdef GATE_WINDOW_REPEAT_EN
    logic [31:0] gap;
    logic [15:0] repeats;
`endif
    logic        set_strobe;
    logic        reset_strobe;
    logic        busy;
    logic        done;
    logic        q;

    logic [31:0] h_set;
    logic [31:0] h_rst;
    logic [31:0] h_busy;
    logic [31:0] h_done;
    logic [31:0] h_q;
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    gate_window_sequencer u_dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .abort        (abort),
        .delay        (delay),
        .width        (width),
`ifdef GATE_WINDOW_REPEAT_EN
        .gap          (gap),
        .repeats      (repeats),
`endif
        .set_strobe   (set_strobe),
        .reset_strobe (reset_strobe),
        .busy         (busy),
        .done         (done)
    );

    // Downstream set_reset flop model.
    always @(posedge clock) begin
        if (!reset_n)          q <= 1'b0;
        else if (reset_strobe) q <= 1'b0;
        else if (set_strobe)   q <= 1'b1;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic record(input int k);
        h_set[k]  = set_strobe;
        h_rst[k]  = reset_strobe;
        h_busy[k] = busy;
        h_done[k] = done;
        h_q[k]    = q;
    endtask

    // Start is sampled at edge S; afterwards the inputs are scrambled to show
    // that only the latched copies matter.
    task automatic launch(input logic [31:0] d, input logic [31:0] w);
        delay = d;
        width = w;
        start = 1'b1;
        step();
        start = 1'b0;
        delay = 32'd7;
        width = 32'd1;
    endtask

    task automatic run(input int n, input int start_at, input int abort_at, input int rst_at);
        h_set = '0; h_rst = '0; h_busy = '0; h_done = '0; h_q = '0;
        record(0);
        for (int k = 1; k <= n; k++) begin
            start   = (k == start_at);
            abort   = (k == abort_at);
            reset_n = !(k == rst_at);
            step();
            record(k);
        end
        start   = 1'b0;
        abort   = 1'b0;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        delay   = '0;
        width   = '0;
`ifdef GATE_WINDOW_REPEAT_EN
        gap     = '0;
        repeats = '0;
`endif
        step(); step(); step();
        check("reset_set",  {31'd0, set_strobe},   32'd0);
        check("reset_rst",  {31'd0, reset_strobe}, 32'd0);
        check("reset_busy", {31'd0, busy},         32'd0);
        check("reset_done", {31'd0, done},         32'd0);
        reset_n = 1'b1;
        step();

        // delay=3, width=5, single window
        launch(32'd3, 32'd5);
        run(14, 0, 0, 0);
        check("d3w5_set",  h_set,  32'h0000_0010);
        check("d3w5_rst",  h_rst,  32'h0000_0200);
        check("d3w5_done", h_done, 32'h0000_0200);
        check("d3w5_busy", h_busy, 32'h0000_03FE);
        check("d3w5_q",    h_q,    32'h0000_03E0);

        // delay=0, width=0 -> minimum one-cycle window
        launch(32'd0, 32'd0);
        run(6, 0, 0, 0);
        check("d0w0_set",  h_set,  32'h0000_0002);
        check("d0w0_rst",  h_rst,  32'h0000_0004);
        check("d0w0_busy", h_busy, 32'h0000_0006);
        check("d0w0_done", h_done, 32'h0000_0004);

        // abort while HIGH, sampled at S+5
        launch(32'd2, 32'd10);
        run(12, 0, 5, 0);
        check("abh_set",  h_set,  32'h0000_0008);
        check("abh_rst",  h_rst,  32'h0000_0040);
        check("abh_done", h_done, 32'h0000_0000);
        check("abh_busy", h_busy, 32'h0000_003E);
        check("abh_q",    h_q,    32'h0000_0070);

        // abort while DELAY, sampled at S+2
        launch(32'd5, 32'd3);
        run(12, 0, 2, 0);
        check("abd_set",  h_set,  32'h0000_0000);
        check("abd_rst",  h_rst,  32'h0000_0000);
        check("abd_done", h_done, 32'h0000_0000);
        check("abd_busy", h_busy, 32'h0000_0006);

        // start while busy is ignored
        launch(32'd3, 32'd5);
        run(14, 2, 0, 0);
        check("sib_set",  h_set,  32'h0000_0010);
        check("sib_rst",  h_rst,  32'h0000_0200);
        check("sib_done", h_done, 32'h0000_0200);

        // start together with abort in IDLE: no run
        delay = 32'd0;
        width = 32'd0;
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        run(8, 0, 0, 0);
        check("sa_busy", h_busy, 32'h0000_0000);
        check("sa_set",  h_set,  32'h0000_0000);

        launch(32'd1, 32'd2);
        run(8, 0, 0, 0);
        check("d1w2_set",  h_set,  32'h0000_0004);
        check("d1w2_rst",  h_rst,  32'h0000_0010);
        check("d1w2_done", h_done, 32'h0000_0010);

        // reset_n low mid-run, sampled at S+5
        launch(32'd1, 32'd8);
        run(16, 0, 0, 5);
        check("rmr_set",  h_set,  32'h0000_0004);
        check("rmr_rst",  h_rst,  32'h0000_0000);
        check("rmr_busy", h_busy, 32'h0000_001E);
        check("rmr_done", h_done, 32'h0000_0000);
        check("rmr_q",    h_q,    32'h0000_0018);

        launch(32'd3, 32'd5);
        run(14, 0, 0, 0);
        check("fresh_set",  h_set,  32'h0000_0010);
        check("fresh_rst",  h_rst,  32'h0000_0200);
        check("fresh_done", h_done, 32'h0000_0200);

`ifdef GATE_WINDOW_REPEAT_EN
        // delay=2, width=4, gap=3, repeats=3
        gap     = 32'd3;
        repeats = 16'd3;
        launch(32'd2, 32'd4);
        gap     = 32'd9;
        repeats = 16'd1;
        run(26, 0, 0, 0);
        check("rep_set",     h_set,         32'h0002_0408);
        check("rep_rst",     h_rst,         32'h0020_4080);
        check("rep_done",    h_done,        32'h0020_0000);
        check("rep_busy",    h_busy,        32'h003F_FFFE);
        check("rep_overlap", h_set & h_rst, 32'h0000_0000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_gate_window_sequencer

`default_nettype wire
